// File: rtl/ft_pkg.sv
// Shared types and constants for the FT600 write-direction packer.
// Used by the packer top, its buffer FIFO and the bus interface.
package ft_pkg;

    localparam int FT_WORD_W = 16;
    localparam int FT_BE_W   = 2;
    localparam int FT_ENT_W  = FT_WORD_W + FT_BE_W;

    localparam logic [FT_BE_W-1:0] BE_FULL = 2'b11;
    localparam logic [FT_BE_W-1:0] BE_LOW  = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        GAP
    } ft_state_e;

    typedef struct packed {
        logic [FT_BE_W-1:0]   be;
        logic [FT_WORD_W-1:0] data;
    } ft_ent_t;

endpackage

// File: rtl/ft_tx_packer_if.sv
// Byte-stream input and FT600 write-side bus of ft_tx_packer.
// master = producer/top-level side, slave = the packer.
interface ft_tx_packer_if
    import ft_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
);
    logic [7:0]                    in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic                          ft_txe;
    logic                          ft_wr;
    logic [FT_WORD_W-1:0]          ft_data_out;
    logic [FT_BE_W-1:0]            ft_be_out;
    logic                          ft_data_oe;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic [15:0]                   burst_count;

    modport master (
        output in_data, in_valid, ft_txe,
        input  in_ready, ft_wr, ft_data_out, ft_be_out,
        input  ft_data_oe, fifo_level, burst_count
    );

    modport slave (
        input  in_data, in_valid, ft_txe,
        output in_ready, ft_wr, ft_data_out, ft_be_out,
        output ft_data_oe, fifo_level, burst_count
    );
endinterface

// File: rtl/ft_sync_fifo.sv
// First-word-fall-through synchronous FIFO, power-of-two depth.
// A push into a full FIFO is taken only when a pop happens on the same edge.
module ft_sync_fifo
    import ft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = FT_ENT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wp_q, wp_d;
    logic [AW:0]  rp_q, rp_d;
    logic         do_push, do_pop;

    assign level   = wp_q - rp_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rp_q[AW-1:0]];

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (do_push) wp_d = wp_q + 1'b1;
        if (do_pop)  rp_d = rp_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage is not reset; empty/level gate everything read from it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ft_tx_packer.sv
// Packs a byte stream into 16-bit words and bursts them to the FT600.
// Optional lone-byte flush is enabled with `define FT_TX_FLUSH_EN.
module ft_tx_packer
    import ft_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_BURST    = 512,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    ft_tx_packer_if.slave bus
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    logic          accept, push, pop, full, empty;
    logic [LW-1:0] level;
    ft_ent_t       wr_ent, head;
    logic          start, xfer;

    logic          pend_q, pend_d;
    logic [7:0]    lo_q, lo_d;
    ft_state_e     state_q, state_d;
    logic          wr_n_q, wr_n_d;
    logic          oe_q, oe_d;
    logic [BW-1:0] wcnt_q, wcnt_d;
    logic [15:0]   burst_q, burst_d;

    ft_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FT_ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_ent),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign bus.in_ready = !rst && !full;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef FT_TX_FLUSH_EN
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          flush_due;

    assign flush_due = (fcnt_q == FW'(FLUSH_CYCLES - 1));

    // Counts idle edges while a lone byte waits; saturates at timeout.
    always_comb begin
        fcnt_d = fcnt_q;
        if (accept || !pend_q)
            fcnt_d = '0;
        else if (!flush_due)
            fcnt_d = fcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) fcnt_q <= '0;
        else     fcnt_q <= fcnt_d;
    end
`endif

    always_comb begin
        pend_d = pend_q;
        lo_d   = lo_q;
        push   = 1'b0;
        wr_ent = '{be: BE_FULL, data: {bus.in_data, lo_q}};
        if (accept) begin
            if (pend_q) begin
                push   = 1'b1;
                pend_d = 1'b0;
            end else begin
                lo_d   = bus.in_data;
                pend_d = 1'b1;
            end
        end
`ifdef FT_TX_FLUSH_EN
        else if (pend_q && flush_due && (!full || pop)) begin
            push   = 1'b1;
            pend_d = 1'b0;
            wr_ent = '{be: BE_LOW, data: {8'h00, lo_q}};
        end
`endif
    end

    assign start = !empty && !bus.ft_txe;
    assign xfer  = (state_q == WRITE) && !bus.ft_txe;
    assign pop   = xfer;

    always_comb begin
        state_d = state_q;
        wr_n_d  = wr_n_q;
        oe_d    = oe_q;
        wcnt_d  = wcnt_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE, GAP: begin
                if (start) begin
                    state_d = WRITE;
                    wr_n_d  = 1'b0;
                    oe_d    = 1'b1;
                    wcnt_d  = '0;
                end else begin
                    state_d = IDLE;
                    wr_n_d  = 1'b1;
                    oe_d    = 1'b0;
                end
            end
            WRITE: begin
                if (bus.ft_txe) begin
                    state_d = IDLE;
                    wr_n_d  = 1'b1;
                    oe_d    = 1'b0;
                    burst_d = burst_q + 16'd1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                    // Burst cap wins over FIFO-empty; either ends the burst once.
                    if (wcnt_d == BW'(MAX_BURST)) begin
                        state_d = GAP;
                        wr_n_d  = 1'b1;
                        oe_d    = 1'b0;
                        burst_d = burst_q + 16'd1;
                    end else if (level == LW'(1) && !push) begin
                        state_d = IDLE;
                        wr_n_d  = 1'b1;
                        oe_d    = 1'b0;
                        burst_d = burst_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                wr_n_d  = 1'b1;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 1'b0;
            lo_q    <= '0;
            state_q <= IDLE;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            wcnt_q  <= '0;
            burst_q <= '0;
        end else begin
            pend_q  <= pend_d;
            lo_q    <= lo_d;
            state_q <= state_d;
            wr_n_q  <= wr_n_d;
            oe_q    <= oe_d;
            wcnt_q  <= wcnt_d;
            burst_q <= burst_d;
        end
    end

    assign bus.ft_wr       = wr_n_q;
    assign bus.ft_data_oe  = oe_q;
    assign bus.ft_data_out = oe_q ? head.data : '0;
    assign bus.ft_be_out   = oe_q ? head.be : '0;
    assign bus.fifo_level  = level;
    assign bus.burst_count = burst_q;

endmodule

// File: tb/tb_ft_tx_packer.sv
// Scoreboard bench for ft_tx_packer (MAX_BURST=4, FLUSH_CYCLES=8).
// Build with FT_TX_FLUSH_EN defined to exercise the lone-byte flush.
module tb_ft_tx_packer;
    import ft_pkg::*;

    localparam int DEPTH = 16;
    localparam int MB    = 4;
    localparam int FC    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ft_tx_packer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ft_tx_packer #(
        .FIFO_DEPTH   (DEPTH),
        .MAX_BURST    (MB),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int xfers  = 0;
    int wr_low = 0;
    logic [17:0] exp_q[$];
    bit          pend_b = 1'b0;
    logic [7:0]  lo_b   = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: a transfer is any edge with ft_wr=0 and ft_txe=0.
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.ft_wr) wr_low++;
            if (!bus.ft_wr && !bus.ft_txe) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_xfer: got %0h expected none",
                             {bus.ft_be_out, bus.ft_data_out});
                end else begin
                    check("xfer_word", {14'd0, bus.ft_be_out, bus.ft_data_out},
                          {14'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int   k;
        logic r;
        k = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        do begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!r && k < 200);
        bus.in_valid = 1'b0;
        if (!r) fail_now("send_timeout");
        else if (pend_b) begin
            exp_q.push_back({BE_FULL, b, lo_b});
            pend_b = 1'b0;
        end else begin
            lo_b   = b;
            pend_b = 1'b1;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        cycles(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] pat;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.ft_txe   = 1'b1;
        cycles(2);
        @(negedge clk);
        check("rst_ft_wr", bus.ft_wr, 1);
        check("rst_oe", bus.ft_data_oe, 0);
        check("rst_data", bus.ft_data_out, 0);
        check("rst_be", bus.ft_be_out, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_bursts", bus.burst_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Basic pairing and a single 2-word burst
        bus.ft_txe = 1'b0;
        wr_low = 0;
        xfers  = 0;
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        drain();
        check("t1_wr_low_cycles", wr_low, 2);
        check("t1_xfers", xfers, 2);
        check("t1_bursts", bus.burst_count, 1);

        // Flow control stop after one word
        bus.ft_txe = 1'b1;
        for (int i = 1; i <= 8; i++) send(8'(i));
        check("t2_level_4", bus.fifo_level, 4);
        xfers = 0;
        bus.ft_txe = 1'b0;
        cycles(2);
        bus.ft_txe = 1'b1;
        cycles(2);
        check("t2_one_xfer", xfers, 1);
        check("t2_level_3", bus.fifo_level, 3);
        check("t2_wr_high", bus.ft_wr, 1);
        check("t2_bursts", bus.burst_count, 2);
        bus.ft_txe = 1'b0;
        drain();
        check("t2_bursts_drained", bus.burst_count, 3);

        // Fill to full with the bus stalled
        bus.ft_txe = 1'b1;
        for (int i = 0; i < 32; i++) send(8'(8'h40 + i));
        check("t3_in_ready_full", bus.in_ready, 0);
        check("t3_level_full", bus.fifo_level, 16);
        bus.ft_txe = 1'b0;
        drain();
        check("t3_level_empty", bus.fifo_level, 0);
        check("t3_bursts", bus.burst_count, 7);

        // Burst cap: 4,4,2 with single-cycle gaps
        bus.ft_txe = 1'b1;
        for (int i = 0; i < 20; i++) send(8'(8'h80 + i));
        bus.ft_txe = 1'b0;
        pat = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pat = {pat[18:0], bus.ft_wr};
        end
        cycles(1);
        check("t4_wr_pattern", pat, 20'h8427F);
        check("t4_bursts", bus.burst_count, 10);
        check("t4_level", bus.fifo_level, 0);
        check("t4_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a burst
        bus.ft_txe = 1'b1;
        for (int i = 0; i < 12; i++) send(8'(8'hD0 + i));
        bus.ft_txe = 1'b0;
        cycles(3);
        check("t5_in_burst", bus.ft_wr, 0);
        rst = 1'b1;
        exp_q.delete();
        pend_b = 1'b0;
        cycles(1);
        check("t5_rst_wr", bus.ft_wr, 1);
        check("t5_rst_oe", bus.ft_data_oe, 0);
        check("t5_rst_level", bus.fifo_level, 0);
        check("t5_rst_bursts", bus.burst_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready_again", bus.in_ready, 1);
        @(posedge clk);
        #1;
        send(8'hC3); send(8'h3C);
        drain();
        check("t5_bursts", bus.burst_count, 1);

`ifdef FT_TX_FLUSH_EN
        // Lone byte flushed after FLUSH_CYCLES idle edges
        bus.ft_txe = 1'b1;
        send(8'hA5);
        cycles(FC - 1);
        check("t6_no_flush_yet", bus.fifo_level, 0);
        cycles(1);
        check("t6_flushed", bus.fifo_level, 1);
        exp_q.push_back({BE_LOW, 16'h00A5});
        pend_b = 1'b0;
        bus.ft_txe = 1'b0;
        drain();
        check("t6_bursts", bus.burst_count, 2);
`else
        // Lone byte waits for its partner
        bus.ft_txe = 1'b1;
        send(8'h5A);
        cycles(20);
        check("t6_lone_waits", bus.fifo_level, 0);
        send(8'hA5);
        check("t6_paired", bus.fifo_level, 1);
        bus.ft_txe = 1'b0;
        drain();
        check("t6_bursts", bus.burst_count, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
